// File: rtl/mat_mult_pkg.sv
// ---------------------------------------------------------------------------
// mat_mult_pkg
// Shared types and constants for the matrix-multiply controller slice.
//   MAT_N     : default matrix dimension
//   FIX_W     : width of a signed Q11.16 fixed-point value
//   fix27_t   : one Q11.16 value
//   fix27_mat_t : MAT_N x MAT_N matrix of fix27_t, indexed [row][col]
//   mm_state_t  : controller FSM states
// ---------------------------------------------------------------------------
package mat_mult_pkg;

   localparam int MAT_N    = 6;
   localparam int FIX_W    = 27;
   localparam int FIX_FRAC = 16;

   typedef logic signed [FIX_W-1:0] fix27_t;
   typedef fix27_t [MAT_N-1:0][MAT_N-1:0] fix27_mat_t;

   // Most positive and most negative representable Q11.16 values.
   localparam fix27_t FIX_MAX = 27'sh3FFFFFF;
   localparam fix27_t FIX_MIN = 27'sh4000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mm_state_t;

endpackage

// File: rtl/mat_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// mat_mult_ctrl_if
// Bundles the request/response handshake and the multiplier-array bus.
//   start, hold          : requester -> controller
//   mat_a, mat_b         : operand matrices, sampled on acceptance
//   busy, done, mat_c    : controller status and product matrix
//   mult_en, mult_dataa,
//   mult_datab           : controller -> multiplier array
//   mult_result          : multiplier array -> controller
// Modports: master = requester/array side, slave = controller.
// ---------------------------------------------------------------------------
interface mat_mult_ctrl_if
   import mat_mult_pkg::*;
#(
   parameter int N = MAT_N
);

   logic                      start;
   logic                      hold;
   fix27_t [N-1:0][N-1:0]     mat_a;
   fix27_t [N-1:0][N-1:0]     mat_b;
   logic                      busy;
   logic                      done;
   fix27_t [N-1:0][N-1:0]     mat_c;
   logic                      mult_en;
   fix27_t [N-1:0][N-1:0]     mult_dataa;
   fix27_t [N-1:0][N-1:0]     mult_datab;
   fix27_t [N-1:0][N-1:0]     mult_result;

   modport master (
      output start, hold, mat_a, mat_b, mult_result,
      input  busy, done, mat_c, mult_en, mult_dataa, mult_datab
   );

   modport slave (
      input  start, hold, mat_a, mat_b, mult_result,
      output busy, done, mat_c, mult_en, mult_dataa, mult_datab
   );

endinterface

// File: rtl/mat_acc.sv
// ---------------------------------------------------------------------------
// mat_acc
// N x N array of 27-bit signed accumulators.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_clear          : zero every accumulator (takes priority over i_en)
//   i_en             : add i_addend into every accumulator
//   i_addend         : per-element value to add
//   o_acc            : current accumulator contents
// Build option: MAT_MULT_SAT_EN makes the add saturate at the 27-bit signed
// extremes; without it the add wraps modulo 2^27.
// ---------------------------------------------------------------------------
module mat_acc
   import mat_mult_pkg::*;
#(
   parameter int N = MAT_N
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_clear,
   input  logic                  i_en,
   input  fix27_t [N-1:0][N-1:0] i_addend,
   output fix27_t [N-1:0][N-1:0] o_acc
);

   fix27_t [N-1:0][N-1:0] r_acc;
   fix27_t [N-1:0][N-1:0] w_next;

   // One extra bit exposes overflow: the top two bits of the sum differ
   // exactly when the true result is outside the 27-bit range.
   function automatic fix27_t addFix(input fix27_t a, input fix27_t b);
      logic [FIX_W:0] sum;
      fix27_t         res;
      sum = {a[FIX_W-1], a} + {b[FIX_W-1], b};
      res = sum[FIX_W-1:0];
`ifdef MAT_MULT_SAT_EN
      if (sum[FIX_W] != sum[FIX_W-1]) begin
         res = sum[FIX_W] ? FIX_MIN : FIX_MAX;
      end
`endif
      return res;
   endfunction

   // Element-wise next value for every accumulator.
   always_comb begin
      w_next = r_acc;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_next[i][j] = addFix(r_acc[i][j], i_addend[i][j]);
         end
      end
   end

   // Clear wins over accumulate so a new job never inherits old sums.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_next;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/mat_mult_ctrl.sv
// ---------------------------------------------------------------------------
// mat_mult_ctrl
// Sequences an external N x N multiplier array to compute C = A x B.
// Pass k drives A[i][k] and B[k][j] to every cell (i,j); a LAT-deep tag
// shift register follows each pass through the array and, when the tag
// leaves, the array result is added into the accumulators (mat_acc).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/hold/mat_a/mat_b in, busy/done/mat_c out,
//                  mult_en/mult_dataa/mult_datab out, mult_result in
// Parameters: N (matrix dimension), LAT (array latency in enabled cycles).
// Build option: MAT_MULT_SAT_EN selects saturating accumulation in mat_acc.
// ---------------------------------------------------------------------------
module mat_mult_ctrl
   import mat_mult_pkg::*;
#(
   parameter int N   = MAT_N,
   parameter int LAT = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   mat_mult_ctrl_if.slave bus
);

   localparam int             KW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]  K_LAST   = KW'(N - 1);
   localparam logic [LAT-1:0] TAG_LAST = LAT'(1) << (LAT - 1);

   mm_state_t             r_state;
   logic [KW-1:0]         r_k;
   logic [LAT-1:0]        r_valid;
   fix27_t [N-1:0][N-1:0] r_matA;
   fix27_t [N-1:0][N-1:0] r_matB;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_multEn;
   logic                  w_issue;
   logic                  w_accEn;
   fix27_t [N-1:0][N-1:0] w_dataA;
   fix27_t [N-1:0][N-1:0] w_dataB;

   // hold must stop the array in the same cycle, so the enable is decoded
   // from the current state rather than registered.
   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_multEn = ((r_state == ISSUE) || (r_state == DRAIN)) && !bus.hold;
   assign w_issue  = (r_state == ISSUE) && !bus.hold;
   assign w_accEn  = w_multEn && r_valid[LAT-1];

   // Broadcast column k of A along rows and row k of B along columns;
   // outside ISSUE the array inputs are parked at zero.
   always_comb begin
      w_dataA = '0;
      w_dataB = '0;
      if (r_state == ISSUE) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               w_dataA[i][j] = r_matA[i][r_k];
               w_dataB[i][j] = r_matB[r_k][j];
            end
         end
      end
   end

   // Controller FSM, operand capture and pass tags. The tags only move on
   // cycles where the array itself advances, so they stay aligned with the
   // data inside the array across any number of held cycles. DRAIN ends on
   // the cycle the last remaining tag leaves, which is also the cycle its
   // result is accumulated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_valid <= '0;
         r_matA  <= '0;
         r_matB  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_multEn) begin
            r_valid[0] <= w_issue;
            for (int t = 1; t < LAT; t++) begin
               r_valid[t] <= r_valid[t-1];
            end
         end
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_matA  <= bus.mat_a;
                  r_matB  <= bus.mat_b;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.hold) begin
                  if (r_k == K_LAST) begin
                     r_k     <= '0;
                     r_state <= DRAIN;
                  end else begin
                     r_k <= r_k + KW'(1);
                  end
               end
            end
            DRAIN: begin
               if (!bus.hold && (r_valid == TAG_LAST)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   mat_acc #(
      .N (N)
   ) u_acc (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_clear   (w_accept),
      .i_en      (w_accEn),
      .i_addend  (bus.mult_result),
      .o_acc     (bus.mat_c)
   );

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.mult_en    = w_multEn;
   assign bus.mult_dataa = w_dataA;
   assign bus.mult_datab = w_dataB;

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mat_mult_ctrl
// Drives mat_mult_ctrl together with a behavioural multiplier array of
// latency LAT. Expected product matrices come from a reference model and
// are queued when a job is started, then compared when done is seen.
// ---------------------------------------------------------------------------
module tb_mat_mult_ctrl;
   import mat_mult_pkg::*;

   localparam int N       = MAT_N;
   localparam int LAT     = 5;
   localparam int MAX_CYC = 60;

   localparam int MODE_DIAG = 0;
   localparam int MODE_FILL = 1;
   localparam int MODE_RAMP = 2;
   localparam int MODE_RAND = 3;

   localparam fix27_t ONE      = 27'sh0010000;
   localparam fix27_t HALF     = 27'sh0008000;
   localparam fix27_t TWO      = 27'sh0020000;
   localparam fix27_t SIX      = 27'sh0060000;
   localparam fix27_t BIG      = 27'sh1000000;
   localparam fix27_t MINUS1   = 27'sh7FF0000;
`ifdef MAT_MULT_SAT_EN
   localparam fix27_t BIG_EXP  = 27'sh3FFFFFF;
`else
   localparam fix27_t BIG_EXP  = 27'sh0000000;
`endif

   typedef fix27_t [N-1:0][N-1:0] mat_t;

   typedef struct {
      string  name;
      int     aMode;
      fix27_t aVal;
      int     bMode;
      fix27_t bVal;
      int     holdStart;
      int     holdLen;
      int     restartCyc;
      int     expDone;
      bit     matchB;
      bit     constCheck;
      fix27_t expConst;
   } vec_t;

   localparam int NVEC = 6;

   logic  clk     = 1'b0;
   logic  reset_n = 1'b0;
   int    checkCount = 0;
   int    errCount   = 0;
   mat_t  expQ[$];
   mat_t  pipe[LAT];
   vec_t  vecs[NVEC];

   mat_mult_ctrl_if #(.N(N)) bus();

   mat_mult_ctrl #(
      .N   (N),
      .LAT (LAT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Rounded Q11.16 product as the array produces it.
   function automatic fix27_t fixMul(input fix27_t a, input fix27_t b);
      logic signed [2*FIX_W-1:0] p;
      fix27_t                    r;
      p = a * b;
      p = (p + 54'sd32768) >>> FIX_FRAC;
      r = p[FIX_W-1:0];
`ifdef MAT_MULT_SAT_EN
      if (p > 54'sd67108863) r = FIX_MAX;
      if (p < -54'sd67108864) r = FIX_MIN;
`endif
      return r;
   endfunction

   // Reference accumulate step computed on wide integers.
   function automatic fix27_t accAdd(input fix27_t x, input fix27_t y);
      longint s;
      s = longint'(x) + longint'(y);
`ifdef MAT_MULT_SAT_EN
      if (s > 64'sd67108863) s = 64'sd67108863;
      if (s < -64'sd67108864) s = -64'sd67108864;
`endif
      return s[FIX_W-1:0];
   endfunction

   function automatic mat_t refMult(input mat_t a, input mat_t b);
      mat_t c;
      c = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
               c[i][j] = accAdd(c[i][j], fixMul(a[i][k], b[k][j]));
      return c;
   endfunction

   function automatic mat_t makeMat(input int mode, input fix27_t val);
      mat_t m;
      int   r;
      m = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            case (mode)
               MODE_DIAG: m[i][j] = (i == j) ? val : '0;
               MODE_FILL: m[i][j] = val;
               MODE_RAMP: m[i][j] = fix27_t'((i * N + j) << 16);
               default: begin
                  r = int'($urandom_range(0, 524287)) - 262144;
                  m[i][j] = fix27_t'(r);
               end
            endcase
         end
      end
      return m;
   endfunction

   // Behavioural multiplier array: LAT pipeline stages that only move
   // when mult_en is high.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < LAT; s++) pipe[s] <= '0;
      end else if (bus.mult_en) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               pipe[0][i][j] <= fixMul(bus.mult_dataa[i][j], bus.mult_datab[i][j]);
         for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      end
   end

   assign bus.mult_result = pipe[LAT-1];

   task automatic checkValue(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string name, input mat_t got, input mat_t exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (got[i][j] !== exp[i][j]) begin
                  $display("[TB] FAIL %s: c[%0d][%0d] got %h, expected %h",
                           name, i, j, got[i][j], exp[i][j]);
                  return;
               end
            end
         end
      end
   endtask

   // Runs one job from start to done, checking busy/done/mult_en every
   // cycle, the done cycle, and the product against the scoreboard.
   task automatic applyStimulus(input string name, input mat_t a, input mat_t b,
                                input int holdStart, input int holdLen,
                                input int restartCyc, input int expDone,
                                output mat_t cOut);
      mat_t       expM;
      mat_t       altA;
      int         doneCyc;
      int         profErr;
      int         firstCyc;
      logic [2:0] firstGot;
      logic [2:0] firstExp;
      logic [2:0] expProf;
      logic       held;
      expQ.push_back(refMult(a, b));
      altA     = makeMat(MODE_FILL, 27'sh0030000);
      doneCyc  = 0;
      profErr  = 0;
      firstCyc = 0;
      firstGot = '0;
      firstExp = '0;
      cOut     = '0;
      bus.mat_a = a;
      bus.mat_b = b;
      bus.hold  = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
         held = (holdLen > 0) && (cyc >= holdStart) && (cyc < holdStart + holdLen);
         bus.hold = held;
         if (restartCyc > 0 && (cyc == restartCyc || cyc == restartCyc + 1)) begin
            bus.start = 1'b1;
            bus.mat_a = altA;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         expProf = {cyc < expDone, cyc == expDone, (cyc < expDone) && !held};
         if ({bus.busy, bus.done, bus.mult_en} !== expProf) begin
            if (profErr == 0) begin
               firstCyc = cyc;
               firstGot = {bus.busy, bus.done, bus.mult_en};
               firstExp = expProf;
            end
            profErr++;
         end
         if (bus.done === 1'b1) begin
            doneCyc = cyc;
            cOut    = bus.mat_c;
            break;
         end
         @(posedge clk);
         #1;
      end
      bus.hold  = 1'b0;
      bus.start = 1'b0;
      checkCount++;
      if (profErr != 0) begin
         errCount++;
         $display("[TB] FAIL %s busy/done/en: cycle %0d got %b, expected %b",
                  name, firstCyc, firstGot, firstExp);
      end
      checkValue({name, " done cycle"}, doneCyc, expDone);
      if (expQ.size() == 0) begin
         checkCount++;
         errCount++;
         $display("[TB] FAIL %s scoreboard: got empty queue, expected entry", name);
         expM = '0;
      end else begin
         expM = expQ.pop_front();
         checkOutput({name, " mat_c"}, cOut, expM);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checkValue({name, " done after"}, {31'd0, bus.done}, 32'd0);
      checkOutput({name, " mat_c hold"}, bus.mat_c, expM);
   endtask

   initial begin
      #200000;
      errCount++;
      $display("[TB] FAIL watchdog: got time limit, expected finish");
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      mat_t a;
      mat_t b;
      mat_t c;
      mat_t zeroM;
      zeroM = '0;

      vecs[0] = '{"identity x ramp", MODE_DIAG, ONE, MODE_RAMP, ONE,
                  0, 0, 0, N + LAT + 1, 1'b1, 1'b0, 27'sh0};
      vecs[1] = '{"half x two", MODE_FILL, HALF, MODE_FILL, TWO,
                  0, 0, 0, N + LAT + 1, 1'b0, 1'b1, SIX};
      vecs[2] = '{"hold at k2", MODE_DIAG, ONE, MODE_RAMP, ONE,
                  3, 3, 0, N + LAT + 4, 1'b1, 1'b0, 27'sh0};
      vecs[3] = '{"overflow", MODE_FILL, BIG, MODE_FILL, BIG,
                  0, 0, 0, N + LAT + 1, 1'b0, 1'b1, BIG_EXP};
      vecs[4] = '{"restart ignored", MODE_RAND, ONE, MODE_RAND, ONE,
                  0, 0, 3, N + LAT + 1, 1'b0, 1'b0, 27'sh0};
      vecs[5] = '{"neg hold drain", MODE_FILL, MINUS1, MODE_RAMP, ONE,
                  9, 2, 0, N + LAT + 3, 1'b0, 1'b0, 27'sh0};

      bus.start = 1'b0;
      bus.hold  = 1'b0;
      bus.mat_a = '0;
      bus.mat_b = '0;
      reset_n   = 1'b0;
      repeat (3) @(negedge clk);
      checkValue("reset busy", {31'd0, bus.busy}, 32'd0);
      checkValue("reset done", {31'd0, bus.done}, 32'd0);
      checkValue("reset mult_en", {31'd0, bus.mult_en}, 32'd0);
      checkOutput("reset mat_c", bus.mat_c, zeroM);
      checkOutput("reset dataa", bus.mult_dataa, zeroM);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < NVEC; v++) begin
         a = makeMat(vecs[v].aMode, vecs[v].aVal);
         b = makeMat(vecs[v].bMode, vecs[v].bVal);
         applyStimulus(vecs[v].name, a, b, vecs[v].holdStart, vecs[v].holdLen,
                       vecs[v].restartCyc, vecs[v].expDone, c);
         if (vecs[v].matchB)
            checkOutput({vecs[v].name, " equals B"}, c, b);
         if (vecs[v].constCheck)
            checkOutput({vecs[v].name, " constant"}, c,
                        makeMat(MODE_FILL, vecs[v].expConst));
      end

      // Reset pulse in the middle of DRAIN.
      a = makeMat(MODE_RAND, ONE);
      b = makeMat(MODE_RAND, ONE);
      bus.mat_a = a;
      bus.mat_b = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (N + 1) @(posedge clk);
      #1;
      checkValue("drain busy pre-reset", {31'd0, bus.busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      checkValue("mid-drain reset busy", {31'd0, bus.busy}, 32'd0);
      checkValue("mid-drain reset mult_en", {31'd0, bus.mult_en}, 32'd0);
      checkValue("mid-drain reset done", {31'd0, bus.done}, 32'd0);
      checkOutput("mid-drain reset mat_c", bus.mat_c, zeroM);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      a = makeMat(MODE_RAND, ONE);
      b = makeMat(MODE_RAND, ONE);
      applyStimulus("after reset", a, b, 0, 0, 0, N + LAT + 1, c);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mat_mult_ctrl.md
MAT_MULT_CTRL -- requirements
Module: mat_mult_ctrl

Interface
REQ-001 Parameter N, default 6: matrix dimension; the controlled multiplier array is N x N.
REQ-002 Parameter LAT, default 5: cycles from the array's data inputs to its result, counted in enabled cycles (multiplier pipeline plus rounding register).
REQ-003 Port clk  in  1: sole clock; all state changes on its rising edge.
REQ-004 Port reset_n  in  1: asynchronous, active-low reset.
REQ-005 Port start  in  1: request to compute C = A x B.
REQ-006 Port hold  in  1: freeze request; pauses sequencing and the array.
REQ-007 Ports mat_a, mat_b  in  [N][N][27]: signed Q11.16 operands, sampled on start acceptance.
REQ-008 Port busy  out  1: high from acceptance until done.
REQ-009 Port done  out  1: one-cycle pulse when mat_c is valid.
REQ-010 Port mat_c  out  [N][N][27]: product matrix, signed Q11.16.
REQ-011 Ports mult_en  out  1; mult_dataa, mult_datab  out  [N][N][27]: drive the array's en, dataa, datab.
REQ-012 Port mult_result  in  [N][N][27]: the array's rounded result.

Function
REQ-013 FSM states are IDLE, ISSUE, DRAIN and DONE; the block leaves reset in IDLE.
REQ-014 In IDLE, a sampled start=1 shall latch mat_a and mat_b into internal registers, clear the accumulators, set k=0 and enter ISSUE; hold is ignored in IDLE.
REQ-015 start while not IDLE shall be ignored; operand registers shall not change.
REQ-016 In ISSUE, pass k shall drive mult_dataa[i][j]=A[i][k] and mult_datab[i][j]=B[k][j] with mult_en=1; k increments each unheld cycle; after k=N-1 the FSM enters DRAIN.
REQ-017 A LAT-deep valid shift register, advancing only when mult_en=1, shall tag each issued pass; when the tag exits, acc[i][j] += mult_result[i][j].
REQ-018 In DRAIN, mult_en=1 (data don't-care, driven zero) until the last pass is accumulated, then the FSM enters DONE.
REQ-019 DONE lasts one cycle with done=1, then the FSM returns to IDLE; mat_c equals acc and holds until the next acceptance.
REQ-020 Unheld latency: start sampled at edge 0 -> done high in cycle N+LAT+1; busy high in cycles 1..N+LAT.
REQ-021 hold=1 in ISSUE or DRAIN: mult_en=0, and k, the valid tags and acc are frozen; DONE ignores hold.
REQ-022 Accumulation is 27-bit two's complement; overflow wraps unless REQ-025 applies.
REQ-023 With hold=0, mult_en is high in every cycle from 1 to N+LAT and low in all other cycles.

Reset
REQ-024 reset_n low, including mid-operation, shall immediately force IDLE, k=0, valid tags 0, acc and operands 0, busy=0, done=0, mult_en=0 and mult_data* to 0.

Configuration
REQ-025 With MAT_MULT_SAT_EN defined, accumulation saturates to +0x3FFFFFF or -0x4000000 (27-bit signed extremes); without it, it wraps modulo 2^27.

Structure
REQ-026 The package mat_mult_pkg holds the N default, FIX_W=27, typedef fix27_t, the fix27 matrix typedef and the state enum.
REQ-027 The accumulator array (clear, enable, add, optional saturation) is a sub-module named mat_acc; the FSM, operand mux and valid tags stay in mat_mult_ctrl.

Verification
REQ-028 The bench uses a behavioural array model with latency LAT that obeys mult_en.
REQ-029 A=identity (0x0010000 on the diagonal), B[i][j]=(i*N+j)<<16, start -> mat_c=B, done in cycle N+LAT+1 (12 for defaults).
REQ-030 A all 0x0008000 (0.5), B all 0x0020000 (2.0) -> every mat_c entry 0x0060000 (6.0 for N=6).
REQ-031 hold=1 for 3 cycles during ISSUE at k=2 -> done in cycle N+LAT+4 and mat_c identical to the unheld run.
REQ-032 start re-asserted while busy with changed mat_a -> no effect; result matches the originally sampled operands.
REQ-033 A and B all 0x1000000 -> 0x0000000 without MAT_MULT_SAT_EN; 0x3FFFFFF with it.
REQ-034 reset_n pulsed low during DRAIN -> busy=0, mult_en=0, mat_c=0 at once; a new start then yields a correct result.
